// File: rtl/product_accumulator.sv
// Sums the aligned multiplier products of each frame into a saturating accumulator.
// Latency: result registered LATENCY+1 cycles after the last operand issue of a frame.
// Backpressure: none upstream; a frame completing into an occupied result register is dropped and flagged.
module product_accumulator #(
   parameter int PROD_W  = 16,
   parameter int ACC_W   = 24,
   parameter int CNT_W   = 8,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue_valid_i,
   input  logic              issue_last_i,
   input  logic [PROD_W-1:0] product_i,
   output logic              result_valid_o,
   input  logic              result_ready_i,
   output logic [ACC_W-1:0]  result_sum_o,
   output logic [CNT_W-1:0]  result_count_o,
   output logic              result_sat_o,
   output logic              overflow_o,
   input  logic              clear_overflow_i
);

   localparam logic [0:0]       IDLE    = 1'b0;
   localparam logic [0:0]       ACCUM   = 1'b1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [LATENCY-1:0] dl_valid;
   logic [LATENCY-1:0] dl_last;
   logic               tap_valid;
   logic               tap_last;

   logic [0:0]         state;
   logic [ACC_W-1:0]   acc;
   logic [CNT_W-1:0]   cnt;
   logic               sat;

   logic [ACC_W-1:0]   base_acc;
   logic [CNT_W-1:0]   base_cnt;
   logic               base_sat;
   logic [ACC_W:0]     sum_ext;
   logic [ACC_W-1:0]   nxt_acc;
   logic [CNT_W-1:0]   nxt_cnt;
   logic               nxt_sat;

   logic               frame_done;
   logic               out_hs;
   logic               out_load;
   logic               out_drop;

   assign tap_valid  = dl_valid[LATENCY-1];
   assign tap_last   = dl_last[LATENCY-1];
   assign frame_done = tap_valid & tap_last;
   assign out_hs     = result_valid_o & result_ready_i;
   // A completing frame fits if the register is empty or is being drained this cycle.
   assign out_load   = frame_done & (~result_valid_o | out_hs);
   assign out_drop   = frame_done & ~out_load;

   // Issue tracking pipe, aligned to the multiplier latency; last is qualified by valid on entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dl_valid <= '0;
         dl_last  <= '0;
      end else begin
         dl_valid[0] <= issue_valid_i;
         dl_last[0]  <= issue_valid_i & issue_last_i;
         for (int i = 1; i < LATENCY; i++) begin
            dl_valid[i] <= dl_valid[i-1];
            dl_last[i]  <= dl_last[i-1];
         end
      end
   end

   // Next accumulator value: a fresh frame starts from zero, carry out pins the sum at full scale.
   always_comb begin
      base_acc = '0;
      base_cnt = '0;
      base_sat = 1'b0;
      if (state == ACCUM) begin
         base_acc = acc;
         base_cnt = cnt;
         base_sat = sat;
      end
      sum_ext = {1'b0, base_acc} + {{(ACC_W+1-PROD_W){1'b0}}, product_i};
      nxt_acc = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
      nxt_sat = base_sat | sum_ext[ACC_W];
      nxt_cnt = (&base_cnt) ? base_cnt : base_cnt + CNT_ONE;
   end

   // Frame FSM and accumulator: advance only on an aligned product, close the frame on its last.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         acc   <= '0;
         cnt   <= '0;
         sat   <= 1'b0;
      end else if (tap_valid) begin
         acc   <= nxt_acc;
         cnt   <= nxt_cnt;
         sat   <= nxt_sat;
         state <= tap_last ? IDLE : ACCUM;
      end
   end

   // Result register: load a completed frame, otherwise empty on handshake; holds while stalled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         result_valid_o <= 1'b0;
         result_sum_o   <= '0;
         result_count_o <= '0;
         result_sat_o   <= 1'b0;
      end else if (out_load) begin
         result_valid_o <= 1'b1;
         result_sum_o   <= nxt_acc;
         result_count_o <= nxt_cnt;
         result_sat_o   <= nxt_sat;
      end else if (out_hs) begin
         result_valid_o <= 1'b0;
      end
   end

   // Sticky drop flag; a drop in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow_o <= 1'b0;
      end else if (out_drop) begin
         overflow_o <= 1'b1;
      end else if (clear_overflow_i) begin
         overflow_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: two instances (ACC_W=24 and ACC_W=16) share one stimulus stream.
// A cycle-indexed issue history plus per-frame arithmetic predicts the outputs of both every cycle.
// Directed frames pin literal results; a long random run covers drops, clears, resets and saturation.
module tb_product_accumulator;

   localparam int LAT  = 2;
   localparam int HLEN = 16384;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        issue_valid_i = 1'b0;
   logic        issue_last_i = 1'b0;
   logic [15:0] product_i = '0;
   logic        result_ready_i = 1'b0;
   logic        clear_overflow_i = 1'b0;

   logic        rv24, sat24, ov24;
   logic [23:0] sum24;
   logic [7:0]  cnt24;
   logic        rv16, sat16, ov16;
   logic [15:0] sum16;
   logic [7:0]  cnt16;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int last_rst = -100;

   bit          iss_v [0:HLEN-1];
   bit          iss_l [0:HLEN-1];
   logic [15:0] prod_sched [0:HLEN-1];

   // reference state per instance: index 0 -> ACC_W=24, 1 -> ACC_W=16
   longint m_maxv [2];
   bit     m_open [2];
   longint m_acc  [2];
   int     m_cnt  [2];
   bit     m_sat  [2];
   bit     m_vld  [2];
   longint m_sum  [2];
   int     m_ocnt [2];
   bit     m_osat [2];
   bit     m_ov   [2];

   always #5 clk = ~clk;

   product_accumulator #(.PROD_W(16), .ACC_W(24), .CNT_W(8), .LATENCY(LAT)) dut24 (
      .clk(clk), .rst(rst),
      .issue_valid_i(issue_valid_i), .issue_last_i(issue_last_i), .product_i(product_i),
      .result_valid_o(rv24), .result_ready_i(result_ready_i),
      .result_sum_o(sum24), .result_count_o(cnt24), .result_sat_o(sat24),
      .overflow_o(ov24), .clear_overflow_i(clear_overflow_i)
   );

   product_accumulator #(.PROD_W(16), .ACC_W(16), .CNT_W(8), .LATENCY(LAT)) dut16 (
      .clk(clk), .rst(rst),
      .issue_valid_i(issue_valid_i), .issue_last_i(issue_last_i), .product_i(product_i),
      .result_valid_o(rv16), .result_ready_i(result_ready_i),
      .result_sum_o(sum16), .result_count_o(cnt16), .result_sat_o(sat16),
      .overflow_o(ov16), .clear_overflow_i(clear_overflow_i)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_open[k] = 1'b0; m_acc[k] = 0; m_cnt[k] = 0; m_sat[k] = 1'b0;
         m_vld[k] = 1'b0; m_sum[k] = 0; m_ocnt[k] = 0; m_osat[k] = 1'b0; m_ov[k] = 1'b0;
      end
   endtask

   // One clock cycle of stimulus; the issued product is scheduled to appear LAT cycles later.
   task automatic step(input bit r, input bit v, input bit l, input logic [15:0] p,
                       input bit rdy, input bit clr);
      @(posedge clk);
      #1;
      cyc++;
      rst              = r;
      issue_valid_i    = v;
      issue_last_i     = l;
      result_ready_i   = rdy;
      clear_overflow_i = clr;
      prod_sched[cyc+LAT] = p;
      product_i        = prod_sched[cyc];
      @(negedge clk);
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 16'($urandom), rdy, 1'b0);
   endtask

   // Compare process: check outputs against the reference, then advance it with this cycle's inputs.
   initial begin : monitor
      int     c;
      bit     tv, tl, hs, drop;
      longint s;
      int     n;
      bit     st;
      logic        o_vld, o_sat, o_ov;
      logic [23:0] o_sum;
      logic [7:0]  o_cnt;
      forever begin
         @(negedge clk);
         c = cyc;
         iss_v[c] = issue_valid_i;
         iss_l[c] = issue_last_i;
         for (int k = 0; k < 2; k++) begin
            o_vld = (k == 0) ? rv24 : rv16;
            o_sum = (k == 0) ? sum24 : {8'h00, sum16};
            o_cnt = (k == 0) ? cnt24 : cnt16;
            o_sat = (k == 0) ? sat24 : sat16;
            o_ov  = (k == 0) ? ov24 : ov16;
            if (!rst) begin
               chk(k ? "rst_vld16" : "rst_vld24", 32'(o_vld), 32'd0);
               chk(k ? "rst_sum16" : "rst_sum24", 32'(o_sum), 32'd0);
               chk(k ? "rst_cnt16" : "rst_cnt24", 32'(o_cnt), 32'd0);
               chk(k ? "rst_sat16" : "rst_sat24", 32'(o_sat), 32'd0);
               chk(k ? "rst_ovf16" : "rst_ovf24", 32'(o_ov), 32'd0);
            end else begin
               chk(k ? "vld16" : "vld24", 32'(o_vld), 32'(m_vld[k]));
               chk(k ? "ovf16" : "ovf24", 32'(o_ov), 32'(m_ov[k]));
               if (m_vld[k]) begin
                  chk(k ? "sum16" : "sum24", 32'(o_sum), 32'(m_sum[k]));
                  chk(k ? "cnt16" : "cnt24", 32'(o_cnt), 32'(m_ocnt[k]));
                  chk(k ? "sat16" : "sat24", 32'(o_sat), 32'(m_osat[k]));
               end
            end
         end
         if (!rst) begin
            model_reset();
            last_rst = c;
         end else begin
            // an issue survives to the tap only if no reset cycle lies between issue and tap
            tv = (c >= LAT) && iss_v[c-LAT] && ((c - LAT) > last_rst);
            tl = tv && iss_l[c-LAT];
            for (int k = 0; k < 2; k++) begin
               hs = m_vld[k] && result_ready_i;
               drop = 1'b0;
               if (tv) begin
                  if (!m_open[k]) begin
                     s = longint'(product_i); n = 1; st = 1'b0;
                  end else begin
                     s = m_acc[k] + longint'(product_i);
                     st = m_sat[k];
                     n = (m_cnt[k] >= 255) ? 255 : m_cnt[k] + 1;
                  end
                  if (s > m_maxv[k]) begin
                     s = m_maxv[k];
                     st = 1'b1;
                  end
                  m_acc[k] = s; m_cnt[k] = n; m_sat[k] = st; m_open[k] = !tl;
               end
               if (tl) begin
                  if (!m_vld[k] || hs) begin
                     m_vld[k] = 1'b1; m_sum[k] = m_acc[k]; m_ocnt[k] = m_cnt[k]; m_osat[k] = m_sat[k];
                  end else begin
                     drop = 1'b1;
                  end
               end else if (hs) begin
                  m_vld[k] = 1'b0;
               end
               if (drop) m_ov[k] = 1'b1;
               else if (clear_overflow_i) m_ov[k] = 1'b0;
            end
         end
      end
   end

   initial begin : stimulus
      bit          r, v, l, rdy, clr;
      logic [15:0] p;
      m_maxv[0] = (64'd1 << 24) - 1;
      m_maxv[1] = (64'd1 << 16) - 1;
      model_reset();
      for (int i = 0; i < HLEN; i++) prod_sched[i] = 16'($urandom);

      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      idle(3, 1'b1);

      // three-product frame: 10+20+30, result appears 3 cycles after the last issue
      step(1'b1, 1'b1, 1'b0, 16'd10, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 16'd20, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 16'd30, 1'b1, 1'b0);
      idle(2, 1'b1);
      chk("t1_not_early", 32'(rv24), 32'd0);
      idle(1, 1'b1);
      chk("t1_vld", 32'(rv24), 32'd1);
      chk("t1_sum", 32'(sum24), 32'd60);
      chk("t1_cnt", 32'(cnt24), 32'd3);
      chk("t1_sat", 32'(sat24), 32'd0);

      // back-to-back single-product frames with ready held high
      step(1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);
      idle(2, 1'b1);
      chk("t2_sum_a", 32'(sum24), 32'h00FFFF);
      chk("t2_cnt_a", 32'(cnt24), 32'd1);
      idle(1, 1'b1);
      chk("t2_vld_b", 32'(rv24), 32'd1);
      chk("t2_sum_b", 32'(sum24), 32'd1);
      chk("t2_ovf", 32'(ov24), 32'd0);

      // saturation in the 16-bit instance, then a fresh frame clears sat
      step(1'b1, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b0);
      idle(2, 1'b1);
      chk("t3_sum16", 32'(sum16), 32'hFFFF);
      chk("t3_sat16", 32'(sat16), 32'd1);
      chk("t3_cnt16", 32'(cnt16), 32'd2);
      chk("t3_sum24", 32'(sum24), 32'h010001);
      chk("t3_sat24", 32'(sat24), 32'd0);
      idle(1, 1'b1);
      chk("t3_next_sum16", 32'(sum16), 32'd5);
      chk("t3_next_sat16", 32'(sat16), 32'd0);
      idle(3, 1'b1);

      // stalled consumer: second frame dropped, flag cleared, held result drained
      step(1'b1, 1'b1, 1'b1, 16'd7, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 16'd9, 1'b0, 1'b0);
      idle(3, 1'b0);
      chk("t4_hold_vld", 32'(rv24), 32'd1);
      chk("t4_hold_sum", 32'(sum24), 32'd7);
      chk("t4_ovf_set", 32'(ov24), 32'd1);
      step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
      idle(1, 1'b0);
      chk("t4_ovf_clr", 32'(ov24), 32'd0);
      chk("t4_still_7", 32'(sum24), 32'd7);
      idle(1, 1'b1);
      idle(1, 1'b1);
      chk("t4_drained", 32'(rv24), 32'd0);

      // completion coincides with the handshake of the held result
      step(1'b1, 1'b1, 1'b1, 16'd11, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 16'd13, 1'b0, 1'b0);
      idle(1, 1'b0);
      idle(1, 1'b1);
      chk("t5_held", 32'(sum24), 32'd11);
      idle(1, 1'b1);
      chk("t5_vld", 32'(rv24), 32'd1);
      chk("t5_sum", 32'(sum24), 32'd13);
      chk("t5_ovf", 32'(ov24), 32'd0);
      idle(1, 1'b1);

      // reset mid-frame with a result held; issues during reset never count
      step(1'b1, 1'b1, 1'b1, 16'd3, 1'b0, 1'b0);
      idle(3, 1'b0);
      step(1'b1, 1'b1, 1'b0, 16'd100, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 16'd100, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 16'd100, 1'b0, 1'b0);
      chk("t6_rst_vld", 32'(rv24), 32'd0);
      chk("t6_rst_sum", 32'(sum24), 32'd0);
      step(1'b0, 1'b1, 1'b1, 16'd50, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 16'd4, 1'b1, 1'b0);
      idle(2, 1'b1);
      chk("t6_no_stale", 32'(rv24), 32'd0);
      idle(1, 1'b1);
      chk("t6_sum", 32'(sum24), 32'd4);
      chk("t6_cnt", 32'(cnt24), 32'd1);

      // random short frames with stalls, clears and rare resets
      for (int i = 0; i < 3000; i++) begin
         r   = ($urandom_range(0, 499) != 0);
         v   = ($urandom_range(0, 3) != 0);
         l   = ($urandom_range(0, 4) == 0);
         p   = ($urandom_range(0, 3) == 0) ? (16'hFF00 | 16'($urandom_range(0, 255))) : 16'($urandom);
         rdy = ($urandom_range(0, 2) != 0);
         clr = ($urandom_range(0, 15) == 0);
         step(r, v, l, p, rdy, clr);
      end
      // random long frames to reach count saturation
      for (int i = 0; i < 2500; i++) begin
         v   = ($urandom_range(0, 7) != 0);
         l   = ($urandom_range(0, 399) == 0);
         p   = 16'($urandom);
         rdy = ($urandom_range(0, 7) != 0);
         clr = ($urandom_range(0, 31) == 0);
         step(1'b1, v, l, p, rdy, clr);
      end
      idle(6, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
